// File: rtl/axi_slave_error_responder.sv
// AXI4 slave terminator: completes every write/read burst with RESP_CODE and FILL_DATA (MODE=0: all outputs 0).
// Read beats start 1 cycle after the address handshake; write response 1 cycle after WLAST; ready/valid stalls hold all outputs.
module axi_slave_error_responder #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          WR_ID_W   = 2,
  parameter int          RD_ID_W   = 4,
  parameter logic [31:0] FILL_DATA = 32'hDEAD_BEEF,
  parameter logic [1:0]  RESP_CODE = 2'b11,
  parameter bit          MODE      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     WR_ADDR,
  input  logic [7:0]            WR_LEN,
  input  logic [WR_ID_W-1:0]    WR_ID,
  input  logic                  WR_ADDR_VALID,
  output logic                  WR_ADDR_READY,
  input  logic [DATA_W-1:0]     WR_DATA,
  input  logic [DATA_W/8-1:0]   WR_STRB,
  input  logic                  WR_DATA_VALID,
  output logic                  WR_DATA_READY,
  input  logic                  WR_DATA_LAST,
  output logic [WR_ID_W-1:0]    WR_BACK_ID,
  output logic [1:0]            WR_BACK_RESP,
  output logic                  WR_BACK_VALID,
  input  logic                  WR_BACK_READY,
  output logic                  WR_LEN_ERR,
  input  logic [ADDR_W-1:0]     RD_ADDR,
  input  logic [7:0]            RD_LEN,
  input  logic [RD_ID_W-1:0]    RD_ID,
  input  logic                  RD_ADDR_VALID,
  output logic                  RD_ADDR_READY,
  output logic [DATA_W-1:0]     RD_DATA,
  output logic                  RD_DATA_LAST,
  output logic [RD_ID_W-1:0]    RD_BACK_ID,
  output logic [1:0]            RD_BACK_RESP,
  output logic                  RD_DATA_VALID,
  input  logic                  RD_DATA_READY
);

  localparam logic [DATA_W-1:0] FILL = DATA_W'(FILL_DATA);

  // W_OFF/R_OFF hold the ports quiet through reset and forever when MODE=0
  typedef enum logic [1:0] {W_OFF, W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_OFF, R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [WR_ID_W-1:0] wr_id_q;
  logic [7:0]         wr_len_q;
  logic [8:0]         wr_cnt;
  logic               wr_len_err_q;
  logic [RD_ID_W-1:0] rd_id_q;
  logic [7:0]         rd_len_q;
  logic [7:0]         rd_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rd_last;
  logic unused_inputs;

  assign unused_inputs = ^{WR_ADDR, WR_DATA, WR_STRB, RD_ADDR};

  assign aw_hs = WR_ADDR_VALID & WR_ADDR_READY;
  assign w_hs  = WR_DATA_VALID & WR_DATA_READY;
  assign b_hs  = WR_BACK_VALID & WR_BACK_READY;
  assign ar_hs = RD_ADDR_VALID & RD_ADDR_READY;
  assign r_hs  = RD_DATA_VALID & RD_DATA_READY;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_OFF;
      r_state <= R_OFF;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_OFF:   if (MODE) w_next = W_IDLE;
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && WR_DATA_LAST) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_OFF;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_OFF:   if (MODE) r_next = R_IDLE;
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rd_last) r_next = R_IDLE;
      default: r_next = R_OFF;
    endcase
  end

  // Write burst length is checked only when LAST arrives; the response goes out regardless
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_id_q      <= '0;
      wr_len_q     <= '0;
      wr_cnt       <= '0;
      wr_len_err_q <= 1'b0;
    end else begin
      wr_len_err_q <= 1'b0;
      if (aw_hs) begin
        wr_id_q  <= WR_ID;
        wr_len_q <= WR_LEN;
        wr_cnt   <= '0;
      end else if (w_hs) begin
        wr_cnt <= wr_cnt + 9'd1;
        if (WR_DATA_LAST) wr_len_err_q <= (wr_cnt != {1'b0, wr_len_q});
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_id_q  <= '0;
      rd_len_q <= '0;
      rd_cnt   <= '0;
    end else begin
      if (ar_hs) begin
        rd_id_q  <= RD_ID;
        rd_len_q <= RD_LEN;
        rd_cnt   <= '0;
      end else if (r_hs && !rd_last) begin
        rd_cnt <= rd_cnt + 8'd1;
      end
    end
  end

  assign rd_last = (r_state == R_DATA) && (rd_cnt == rd_len_q);

  assign WR_ADDR_READY = (w_state == W_IDLE);
  assign WR_DATA_READY = (w_state == W_DATA);
  assign WR_BACK_VALID = (w_state == W_RESP);
  assign WR_BACK_ID    = wr_id_q;
  assign WR_BACK_RESP  = (w_state == W_RESP) ? RESP_CODE : 2'b00;
  assign WR_LEN_ERR    = wr_len_err_q;

  assign RD_ADDR_READY = (r_state == R_IDLE);
  assign RD_DATA_VALID = (r_state == R_DATA);
  assign RD_DATA       = (r_state == R_DATA) ? FILL : '0;
  assign RD_DATA_LAST  = rd_last;
  assign RD_BACK_ID    = rd_id_q;
  assign RD_BACK_RESP  = (r_state == R_DATA) ? RESP_CODE : 2'b00;

endmodule

// File: tb/tb_axi_slave_error_responder.sv
// Scoreboard bench for axi_slave_error_responder: stimulus pushes expected beats/responses, a negedge monitor checks them.
module tb_axi_slave_error_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] WR_ADDR, RD_ADDR, WR_DATA, RD_DATA;
  logic [7:0]  WR_LEN, RD_LEN;
  logic [1:0]  WR_ID, WR_BACK_ID, WR_BACK_RESP, RD_BACK_RESP;
  logic [3:0]  RD_ID, RD_BACK_ID, WR_STRB;
  logic WR_ADDR_VALID, WR_ADDR_READY, WR_DATA_VALID, WR_DATA_READY, WR_DATA_LAST;
  logic WR_BACK_VALID, WR_BACK_READY, WR_LEN_ERR;
  logic RD_ADDR_VALID, RD_ADDR_READY, RD_DATA_LAST, RD_DATA_VALID, RD_DATA_READY;

  // MODE=0 instance, own stimulus
  logic [31:0] z_wr_addr, z_rd_addr, z_wr_data, z_rd_data;
  logic [7:0]  z_wr_len, z_rd_len;
  logic [1:0]  z_wr_id, z_wr_back_id, z_wr_back_resp, z_rd_back_resp;
  logic [3:0]  z_rd_id, z_rd_back_id, z_wr_strb;
  logic z_wr_addr_valid, z_wr_addr_ready, z_wr_data_valid, z_wr_data_ready, z_wr_data_last;
  logic z_wr_back_valid, z_wr_back_ready, z_wr_len_err;
  logic z_rd_addr_valid, z_rd_addr_ready, z_rd_data_last, z_rd_data_valid, z_rd_data_ready;

  axi_slave_error_responder u_dut (
    .clk(clk), .rst(rst),
    .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ID(WR_ID),
    .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_VALID(WR_DATA_VALID),
    .WR_DATA_READY(WR_DATA_READY), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP),
    .WR_BACK_VALID(WR_BACK_VALID), .WR_BACK_READY(WR_BACK_READY), .WR_LEN_ERR(WR_LEN_ERR),
    .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_DATA(RD_DATA), .RD_DATA_LAST(RD_DATA_LAST), .RD_BACK_ID(RD_BACK_ID),
    .RD_BACK_RESP(RD_BACK_RESP), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
  );

  axi_slave_error_responder #(.MODE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .WR_ADDR(z_wr_addr), .WR_LEN(z_wr_len), .WR_ID(z_wr_id),
    .WR_ADDR_VALID(z_wr_addr_valid), .WR_ADDR_READY(z_wr_addr_ready),
    .WR_DATA(z_wr_data), .WR_STRB(z_wr_strb), .WR_DATA_VALID(z_wr_data_valid),
    .WR_DATA_READY(z_wr_data_ready), .WR_DATA_LAST(z_wr_data_last),
    .WR_BACK_ID(z_wr_back_id), .WR_BACK_RESP(z_wr_back_resp),
    .WR_BACK_VALID(z_wr_back_valid), .WR_BACK_READY(z_wr_back_ready), .WR_LEN_ERR(z_wr_len_err),
    .RD_ADDR(z_rd_addr), .RD_LEN(z_rd_len), .RD_ID(z_rd_id),
    .RD_ADDR_VALID(z_rd_addr_valid), .RD_ADDR_READY(z_rd_addr_ready),
    .RD_DATA(z_rd_data), .RD_DATA_LAST(z_rd_data_last), .RD_BACK_ID(z_rd_back_id),
    .RD_BACK_RESP(z_rd_back_resp), .RD_DATA_VALID(z_rd_data_valid), .RD_DATA_READY(z_rd_data_ready)
  );

  logic [48:0] all_out, z_all_out;
  assign all_out = {WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
                    WR_LEN_ERR, RD_ADDR_READY, RD_DATA, RD_DATA_LAST, RD_BACK_ID,
                    RD_BACK_RESP, RD_DATA_VALID};
  assign z_all_out = {z_wr_addr_ready, z_wr_data_ready, z_wr_back_id, z_wr_back_resp,
                      z_wr_back_valid, z_wr_len_err, z_rd_addr_ready, z_rd_data,
                      z_rd_data_last, z_rd_back_id, z_rd_back_resp, z_rd_data_valid};

  int tests = 0;
  int failed = 0;
  int err_seen = 0;
  logic [38:0] rdq[$];   // {data, last, id, resp}
  logic [3:0]  wrq[$];   // {id, resp}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare presented beats against the queue head every cycle (covers stall hold), pop on handshake
  always @(negedge clk) begin
    if (RD_DATA_VALID) begin
      if (rdq.size() == 0) check("rd_spurious_beat", 64'(RD_DATA_VALID), 64'd0);
      else begin
        check("rd_beat", 64'({RD_DATA, RD_DATA_LAST, RD_BACK_ID, RD_BACK_RESP}), 64'(rdq[0]));
        if (RD_DATA_READY) void'(rdq.pop_front());
      end
    end
    if (WR_BACK_VALID) begin
      if (wrq.size() == 0) check("wr_spurious_resp", 64'(WR_BACK_VALID), 64'd0);
      else begin
        check("wr_resp", 64'({WR_BACK_ID, WR_BACK_RESP}), 64'(wrq[0]));
        if (WR_BACK_READY) void'(wrq.pop_front());
      end
    end
    if (WR_LEN_ERR) err_seen++;
  end

  task automatic rd_addr(input logic [3:0] id, input logic [7:0] len);
    int n;
    RD_ID = id; RD_LEN = len; RD_ADDR_VALID = 1'b1;
    for (int i = 0; i <= int'(len); i++)
      rdq.push_back({32'hDEAD_BEEF, (i == int'(len)), id, 2'b11});
    @(negedge clk);
    n = 0;
    while (!RD_ADDR_READY && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("rd_addr_timeout", 64'(RD_ADDR_READY), 64'd1);
    @(posedge clk); #1;
    RD_ADDR_VALID = 1'b0;
  endtask

  task automatic wr_burst(input logic [1:0] id, input logic [7:0] len, input int nbeats, input int bdelay);
    int n;
    WR_ID = id; WR_LEN = len; WR_ADDR_VALID = 1'b1;
    wrq.push_back({id, 2'b11});
    @(negedge clk);
    n = 0;
    while (!WR_ADDR_READY && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("wr_addr_timeout", 64'(WR_ADDR_READY), 64'd1);
    @(posedge clk); #1;
    WR_ADDR_VALID = 1'b0;
    check("wr_data_rdy_after_addr", 64'(WR_DATA_READY), 64'd1);
    for (int b = 0; b < nbeats; b++) begin
      WR_DATA_VALID = 1'b1; WR_DATA = $urandom; WR_STRB = 4'hF;
      WR_DATA_LAST = (b == nbeats - 1);
      @(negedge clk);
      n = 0;
      while (!WR_DATA_READY && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("wr_data_timeout", 64'(WR_DATA_READY), 64'd1);
      @(posedge clk); #1;
      WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
    end
    check("wr_resp_after_last", 64'(WR_BACK_VALID), 64'd1);
    check("wr_len_err_pulse", 64'(WR_LEN_ERR), 64'(nbeats != int'(len) + 1));
    repeat (bdelay) @(posedge clk);
    #1;
    check("wr_resp_held", 64'(WR_BACK_VALID), 64'd1);
    WR_BACK_READY = 1'b1;
    @(posedge clk); #1;
    check("wr_idle_after_resp", 64'({WR_BACK_VALID, WR_ADDR_READY}), 64'b01);
    WR_BACK_READY = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    WR_ADDR = '0; WR_LEN = '0; WR_ID = '0; WR_ADDR_VALID = 0; WR_DATA = '0; WR_STRB = '0;
    WR_DATA_VALID = 0; WR_DATA_LAST = 0; WR_BACK_READY = 0;
    RD_ADDR = 32'h1000; RD_LEN = '0; RD_ID = '0; RD_ADDR_VALID = 0; RD_DATA_READY = 0;
    z_wr_addr = '0; z_wr_len = '0; z_wr_id = '0; z_wr_addr_valid = 0; z_wr_data = '0;
    z_wr_strb = '0; z_wr_data_valid = 0; z_wr_data_last = 0; z_wr_back_ready = 0;
    z_rd_addr = '0; z_rd_len = '0; z_rd_id = '0; z_rd_addr_valid = 0; z_rd_data_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(all_out), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("first_edge_addr_rdy", 64'({WR_ADDR_READY, RD_ADDR_READY}), 64'b11);

    // 4-beat read, ready held high: beats on 4 consecutive cycles
    RD_DATA_READY = 1'b1;
    rd_addr(4'hA, 8'd3);
    check("rd_valid_after_addr", 64'(RD_DATA_VALID), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("rd_burst_drained", 64'(rdq.size()), 64'd0);
    check("rd_idle_after_burst", 64'({RD_ADDR_READY, RD_DATA_VALID}), 64'b10);

    // single-beat read
    rd_addr(4'h3, 8'd0);
    check("rd_len0_last", 64'({RD_DATA_VALID, RD_DATA_LAST}), 64'b11);
    @(posedge clk); #1;
    check("rd_len0_idle", 64'({RD_ADDR_READY, RD_DATA_VALID}), 64'b10);

    // reset in the middle of an 8-beat read
    rd_addr(4'h5, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_mid_read_outputs", 64'(all_out), 64'd0);
    check("rd_beats_before_reset", 64'(rdq.size()), 64'd5);
    rdq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_addr_rdy", 64'({WR_ADDR_READY, RD_ADDR_READY}), 64'b11);
    repeat (10) @(posedge clk);
    #1;
    check("no_residual_beats", 64'(RD_DATA_VALID), 64'd0);

    // 256-beat read with random backpressure
    RD_DATA_READY = 1'b0;
    rd_addr(4'h7, 8'd255);
    n = 0;
    while (rdq.size() > 0 && n < 3000) begin
      RD_DATA_READY = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("rd_bp_drained", 64'(rdq.size()), 64'd0);
    check("rd_bp_idle", 64'({RD_ADDR_READY, RD_DATA_VALID}), 64'b10);
    RD_DATA_READY = 1'b1;

    // writes: matching length, then response held for 5 cycles
    wr_burst(2'b10, 8'd2, 3, 0);
    wr_burst(2'b01, 8'd2, 3, 5);
    check("wr_no_len_err", 64'(err_seen), 64'd0);

    // length mismatch with a concurrent read
    fork
      wr_burst(2'b11, 8'd3, 2, 0);
      begin
        rd_addr(4'hC, 8'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rd_concurrent_drained", 64'(rdq.size()), 64'd0);
      end
    join
    check("wr_len_err_once", 64'(err_seen), 64'd1);
    check("wr_queue_empty", 64'(wrq.size()), 64'd0);

    // MODE=0 instance: everything asserted, outputs must stay 0
    z_wr_addr_valid = 1; z_wr_data_valid = 1; z_wr_data_last = 1; z_wr_back_ready = 1;
    z_rd_addr_valid = 1; z_rd_data_ready = 1; z_wr_len = 8'd5; z_rd_len = 8'd5;
    z_wr_id = 2'b11; z_rd_id = 4'hF; z_wr_data = 32'h1234_5678; z_wr_strb = 4'hF;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("mode0_outputs", 64'(z_all_out), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axi_slave_error_responder.md
# axi_slave_error_responder

Parametrised AXI4 slave terminator that replaces a never-responding stub on any unpopulated slave port of the AXI interconnect. It completes every write and read burst with a configurable error response and fill data, so an access to an empty address region terminates instead of stalling the master. MODE selects between legacy silent behaviour and active termination; the write and read channels run independently and concurrently.

## Interface
- DATA_W, 32, data width of WR_DATA/RD_DATA; STRB width is DATA_W/8
- ADDR_W, 32, address width
- WR_ID_W, 2, write ID width
- RD_ID_W, 4, read ID width
- FILL_DATA, 32'hDEAD_BEEF, value driven on RD_DATA for every read beat, truncated/zero-extended to DATA_W
- RESP_CODE, 2'b11, response code for both channels (DECERR)
- MODE, 1, 0 = silent (all outputs constant 0), 1 = error responder

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- WR_ADDR  in  ADDR_W  write address (ignored)
- WR_LEN  in  8  write burst length minus 1
- WR_ID  in  WR_ID_W  write ID
- WR_ADDR_VALID / WR_ADDR_READY  in / out  1  write address handshake
- WR_DATA  in  DATA_W  write data (discarded)
- WR_STRB  in  DATA_W/8  byte strobes (ignored)
- WR_DATA_VALID / WR_DATA_READY  in / out  1  write data handshake
- WR_DATA_LAST  in  1  last write beat
- WR_BACK_ID  out  WR_ID_W  write response ID
- WR_BACK_RESP  out  2  write response code
- WR_BACK_VALID / WR_BACK_READY  out / in  1  write response handshake
- WR_LEN_ERR  out  1  one-cycle pulse: WR_DATA_LAST beat count differs from WR_LEN+1
- RD_ADDR  in  ADDR_W  read address (ignored)
- RD_LEN  in  8  read burst length minus 1
- RD_ID  in  RD_ID_W  read ID
- RD_ADDR_VALID / RD_ADDR_READY  in / out  1  read address handshake
- RD_DATA  out  DATA_W  read data
- RD_DATA_LAST  out  1  last read beat
- RD_BACK_ID  out  RD_ID_W  read data ID
- RD_BACK_RESP  out  2  read response code
- RD_DATA_VALID / RD_DATA_READY  out / in  1  read data handshake

## Operation
- Handshake completes on a cycle with VALID & READY both high at the rising edge.
- Write FSM: W_IDLE -> W_DATA on address handshake (capture WR_ID, WR_LEN, clear beat count); W_DATA -> W_RESP on a data handshake with WR_DATA_LAST=1; W_RESP -> W_IDLE on WR_BACK_READY.
- W_DATA counts accepted beats (9-bit). Termination is decided solely by WR_DATA_LAST. If count at LAST != WR_LEN+1, WR_LEN_ERR pulses on the cycle after the LAST handshake; the response is still issued.
- Read FSM: R_IDLE -> R_DATA on address handshake (capture RD_ID, RD_LEN, beat counter = 0); in R_DATA each handshake increments the counter; the handshake at counter == RD_LEN returns to R_IDLE.
- RD_DATA = FILL_DATA on every beat; RD_DATA_LAST = (counter == RD_LEN) while RD_DATA_VALID.
- RD_BACK_ID, RD_BACK_RESP, WR_BACK_ID, WR_BACK_RESP are held stable for the whole burst/response; RESP = RESP_CODE.
- MODE=0: every output is constant 0 and the FSMs are never entered.

## Timing
- Reset (rst low, asynchronous): both FSMs idle; all READY, VALID, LAST and WR_LEN_ERR outputs 0, and all IDs, RESP and RD_DATA 0. Burst in flight is abandoned with no response.
- All outputs are decoded from registers; no combinational input-to-output path.
- First edge after reset release: WR_ADDR_READY and RD_ADDR_READY = 1 (MODE=1).
- WR_ADDR_READY = 1 only in W_IDLE; WR_DATA_READY = 1 only in W_DATA; WR_BACK_VALID = 1 only in W_RESP.
- Address handshake at edge N -> WR_DATA_READY high from cycle N+1. LAST handshake at N -> WR_BACK_VALID high at N+1. Response handshake at N -> WR_ADDR_READY high at N+1, so there is one idle cycle minimum between write bursts.
- RD_ADDR_READY = 1 only in R_IDLE. Address handshake at N -> RD_DATA_VALID high at N+1. A burst of L+1 beats with RD_DATA_READY held high completes at N+L+1. RD_DATA_READY low stalls with data, LAST and ID held.
- LEN = 255 gives 256 beats with no counter wrap. LEN = 0 gives a single beat with LAST high on it.
- Write and read bursts may overlap in time. Simultaneous address handshakes on both channels are both accepted.

## Test plan
- Reset mid-read: RD_LEN=7 with rst asserted after 3 beats -> all outputs 0 immediately. After release, RD_ADDR_READY=1 on the first edge and no residual beats appear.
- Read burst: RD_ID=4'hA, RD_LEN=3, READY always high -> exactly 4 beats of 32'hDEAD_BEEF on consecutive cycles, ID 4'hA, RESP 2'b11, LAST on beat 4 only.
- Read backpressure: RD_LEN=255, RD_DATA_READY toggled randomly -> exactly 256 accepted beats, data/LAST/ID held while stalled, LAST only on beat 256.
- Write burst: WR_ID=2'b10, WR_LEN=2, 3 data beats with LAST on the third -> WR_BACK_VALID one cycle later with ID 2'b10 and RESP 2'b11, WR_LEN_ERR stays 0. Delaying WR_BACK_READY by 5 cycles holds the response.
- Length mismatch and concurrency: WR_LEN=3 with LAST on beat 2, while a read with RD_LEN=1 runs in parallel -> WR_LEN_ERR pulses once and the response is still issued. The read completes unaffected.
- MODE=0 build: drive VALID on all channels for 100 cycles -> every output stays 0.
